mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter REG_LEN, default 32, sets the data and address width.
REQ-002 Parameter TIMEOUT, default 16, sets the maximum number of BUS-state cycles to wait for mem_ack, range 1..255.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, 1, the core presents an access.
REQ-006 Port req_ready, output, 1, the controller accepts an access.
REQ-007 Port req_we, input, 1, 1 = store, 0 = load.
REQ-008 Port req_sel, input, selectPkg::sel_type, access type: SB, SH, SW, SBU or SHU.
REQ-009 Port req_addr, input, REG_LEN, byte address.
REQ-010 Port req_wdata, input, REG_LEN, store data in the low bits.
REQ-011 Port resp_valid, output, 1, one-cycle completion strobe.
REQ-012 Port resp_rdata, output, REG_LEN, extended load result; 0 for stores and errors.
REQ-013 Port resp_err, output, 1, misaligned access or timeout; qualified by resp_valid.
REQ-014 Ports mem_req, mem_we, mem_be[3:0], mem_addr, mem_wdata, outputs, request strobe, write enable, byte enables, word address and write data.
REQ-015 Ports mem_rdata (REG_LEN) and mem_ack (1), inputs, read word and completion.

Function
REQ-016 FSM states SHALL be IDLE, BUS and RESP only.
REQ-017 In IDLE, req_ready SHALL be 1; it SHALL be 0 in BUS and RESP.
REQ-018 The handshake req_valid&&req_ready SHALL latch we, sel, addr and wdata.
REQ-019 Alignment rules: SH/SHU with addr[0]=1, or SW with addr[1:0]!=0, SHALL be misaligned. A misaligned request SHALL go IDLE->RESP with resp_err=1 and no mem_req.
REQ-020 An aligned request SHALL go IDLE->BUS; mem_req SHALL be 1 throughout BUS, and all mem_* outputs SHALL stay stable until ack.
REQ-021 mem_addr SHALL equal {addr[REG_LEN-1:2],2'b00}.
REQ-022 Byte enables: mem_be SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, and 4'b1111 for word; loads drive the same mask.
REQ-023 Store data: mem_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word. Stores with SBU/SHU SHALL behave as SB/SH.
REQ-024 On mem_ack in BUS, a load SHALL capture the selected byte/half of mem_rdata at addr[1:0], sign-extended for SB/SH and zero-extended for SBU/SHU (SW is full word), and the FSM SHALL go to RESP.
REQ-025 A timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack. When it reaches TIMEOUT-1 without ack, the FSM SHALL go to RESP with resp_err=1, mem_req dropping the next cycle.
REQ-026 Ack and timeout in the same cycle: ack SHALL win, with no error.
REQ-027 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE; the next request may be accepted in the following cycle.
REQ-028 Latency: accept at cycle 0, mem_req at cycle 1; with ack at cycle 1, resp_valid SHALL be at cycle 2. A misaligned access SHALL give resp_valid at cycle 1.
REQ-029 mem_ack outside BUS SHALL be ignored.
REQ-030 When not in BUS, mem_req and mem_we SHALL be 0.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, req_ready=1, and resp_valid=resp_err=mem_req=mem_we=0, with mem_be, mem_addr, mem_wdata, resp_rdata and the counter all 0.
REQ-032 Reset during BUS SHALL abandon the access with no response; operation SHALL resume on the first clock after release.

Verification
REQ-033 Load SB, addr 0x103, mem_rdata 0x12345678, ack at cycle 1 -> mem_addr 0x100, mem_be 4'b1000, resp_rdata 0x00000012 at cycle 2.
REQ-034 Load SB / SBU, addr 0x02, mem_rdata 0x00ff0000 -> resp_rdata 0xffffffff / 0x000000ff, resp_err 0.
REQ-035 Store SH, addr 0x102, wdata 0xAAAABEEF, ack after 3 wait cycles -> mem_be 4'b1100, mem_wdata 0xBEEFBEEF, mem_we 1 stable 4 cycles, resp_valid one cycle.
REQ-036 Load SW, addr 0x101 -> mem_req never asserted, resp_valid and resp_err 1 at cycle 1.
REQ-037 Load with no ack, TIMEOUT=16 -> mem_req high 16 cycles, then resp_err 1, resp_rdata 0.
REQ-038 rst_n pulsed low mid-BUS, then ack arrives -> mem_req falls immediately, no resp_valid, and a new request completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Load/store unit between a core request port and a word-wide memory bus.
// It handles sub-word byte lanes, misalignment errors and a bounded wait for mem_ack.
package selectPkg;
    typedef enum logic [2:0] {
        SB  = 3'd0,
        SH  = 3'd1,
        SW  = 3'd2,
        SBU = 3'd3,
        SHU = 3'd4
    } sel_type;
endpackage

module mem_ctrl
    import selectPkg::*;
#(
    parameter int REG_LEN = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  sel_type            req_sel,
    input  logic [REG_LEN-1:0] req_addr,
    input  logic [REG_LEN-1:0] req_wdata,
    output logic               resp_valid,
    output logic [REG_LEN-1:0] resp_rdata,
    output logic               resp_err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [3:0]         mem_be,
    output logic [REG_LEN-1:0] mem_addr,
    output logic [REG_LEN-1:0] mem_wdata,
    input  logic [REG_LEN-1:0] mem_rdata,
    input  logic               mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_misaligned;
    logic               w_timeout;
    logic               w_resp_err;
    logic [REG_LEN-1:0] w_resp_rdata;
    logic [7:0]         r_cnt;
    logic               r_we;
    sel_type            r_sel;
    logic [1:0]         r_off;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [REG_LEN-1:0] r_resp_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [3:0]         r_mem_be;
    logic [REG_LEN-1:0] r_mem_addr;
    logic [REG_LEN-1:0] r_mem_wdata;

    function automatic logic is_misaligned(input sel_type s, input logic [1:0] a);
        case (s)
            SB, SBU: is_misaligned = 1'b0;
            SH, SHU: is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input sel_type s, input logic [1:0] a);
        case (s)
            SB, SBU: lane_mask = 4'b0001 << a;
            SH, SHU: lane_mask = 4'b0011 << a;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [REG_LEN-1:0] store_data(input sel_type s, input logic [REG_LEN-1:0] d);
        case (s)
            SB, SBU: store_data = {(REG_LEN/8){d[7:0]}};
            SH, SHU: store_data = {(REG_LEN/16){d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Loads pick the addressed lane of the bus word, then sign- or zero-extend it.
    function automatic logic [REG_LEN-1:0] load_ext(input sel_type s, input logic [1:0] a,
                                                    input logic [REG_LEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (s)
            SB:      load_ext = {{(REG_LEN-8){b[7]}}, b};
            SBU:     load_ext = {{(REG_LEN-8){1'b0}}, b};
            SH:      load_ext = {{(REG_LEN-16){h[15]}}, h};
            SHU:     load_ext = {{(REG_LEN-16){1'b0}}, h};
            default: load_ext = w;
        endcase
    endfunction

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_misaligned = is_misaligned(req_sel, req_addr[1:0]);
    assign w_timeout    = (r_cnt == 8'(TIMEOUT - 1));

    // Next-state decode plus the response that is registered on entry to RESP.
    always_comb begin
        w_next       = r_state;
        w_resp_err   = 1'b0;
        w_resp_rdata = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_next     = RESP;
                        w_resp_err = 1'b1;
                    end else begin
                        w_next = BUS;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            BUS: begin
                if (mem_ack) begin
                    w_next = RESP;
                    if (r_we) begin
                        w_resp_rdata = '0;
                    end else begin
                        w_resp_rdata = load_ext(r_sel, r_off, mem_rdata);
                    end
                end else if (w_timeout) begin
                    w_next     = RESP;
                    w_resp_err = 1'b1;
                end else begin
                    w_next = BUS;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, bus drive and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 8'd0;
            r_we         <= 1'b0;
            r_sel        <= SB;
            r_off        <= 2'b00;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= (w_next == RESP);
            r_resp_err   <= w_resp_err;
            r_resp_rdata <= w_resp_rdata;
            if (w_accept && !w_misaligned) begin
                r_we        <= req_we;
                r_sel       <= req_sel;
                r_off       <= req_addr[1:0];
                r_cnt       <= 8'd0;
                r_mem_req   <= 1'b1;
                r_mem_we    <= req_we;
                r_mem_be    <= lane_mask(req_sel, req_addr[1:0]);
                r_mem_addr  <= {req_addr[REG_LEN-1:2], 2'b00};
                r_mem_wdata <= store_data(req_sel, req_wdata);
            end else if (r_state == BUS) begin
                if (w_next != BUS) begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: expected responses go into a scoreboard queue
// when a request is issued and are compared whenever resp_valid is seen.
module tb_mem_ctrl;
    import selectPkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    sel_type     req_sel;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_ctrl #(.REG_LEN(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_sel    (req_sel),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every response strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            exp_t e;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected_resp: got err=%0b rdata=%h, required no response",
                         resp_err, resp_rdata);
            end else begin
                e = sb_q.pop_front();
                if ({resp_err, resp_rdata} !== {e.err, e.rdata})
                    $display("FAIL sb_resp: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             resp_err, resp_rdata, e.err, e.rdata);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic [31:0] model_load(sel_type s, logic [1:0] off, logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (s)
            SB:      return 32'(int'($signed(sh[7:0])));
            SBU:     return sh & 32'h0000_00ff;
            SH:      return 32'(int'($signed(sh[15:0])));
            SHU:     return sh & 32'h0000_ffff;
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single accepting edge; returns in cycle 1.
    task automatic issue(input logic we, input sel_type s, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_sel   = s;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_load(input sel_type s, input logic [31:0] a, input logic [31:0] w);
        int k;
        sb_q.push_back('{1'b0, model_load(s, a[1:0], w)});
        issue(1'b0, s, a, 32'h0);
        mem_rdata = w;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        k = 0;
        while (!resp_valid && k < 5) begin
            tick();
            k++;
        end
        n_checks++;
        if (!resp_valid) $display("FAIL load_resp_timeout: no resp_valid within bound, required one");
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b, required 10000",
                     {req_ready, resp_valid, resp_err, mem_req, mem_we});
        else n_pass++;
        n_checks++;
        if ({mem_be, mem_addr, mem_wdata, resp_rdata} !== 100'd0)
            $display("FAIL reset_data: got be=%b addr=%h wdata=%h rdata=%h, required all 0",
                     mem_be, mem_addr, mem_wdata, resp_rdata);
        else n_pass++;
    endtask

    task automatic test_load_sb();
        sb_q.push_back('{1'b0, 32'h0000_0012});
        issue(1'b0, SB, 32'h0000_0103, 32'h0);
        n_checks++;
        if ({mem_req, mem_we, req_ready, mem_be, mem_addr} !== {3'b100, 4'b1000, 32'h0000_0100})
            $display("FAIL sb_bus: got req=%0b we=%0b rdy=%0b be=%b addr=%h, required 1 0 0 1000 00000100",
                     mem_req, mem_we, req_ready, mem_be, mem_addr);
        else n_pass++;
        mem_rdata = 32'h1234_5678;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({resp_valid, mem_req} !== 2'b10)
            $display("FAIL sb_latency: got valid=%0b mem_req=%0b at cycle 2, required 1 0",
                     resp_valid, mem_req);
        else n_pass++;
        tick();
        n_checks++;
        if ({resp_valid, req_ready} !== 2'b01)
            $display("FAIL sb_one_shot: got valid=%0b ready=%0b, required 0 1", resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_extend();
        sel_type sels[4] = '{SB, SBU, SH, SHU};
        do_load(SB,  32'h0000_0002, 32'h00ff_0000);
        do_load(SBU, 32'h0000_0002, 32'h00ff_0000);
        for (int i = 0; i < 4; i++) begin
            for (int off = 0; off < 4; off++) begin
                if (i < 2 || off[0] == 1'b0)
                    do_load(sels[i], 32'h0000_0040 + 32'(off), $urandom());
            end
        end
        do_load(SW, 32'h0000_0044, 32'h8765_4321);
    endtask

    task automatic test_store();
        int stable;
        sb_q.push_back('{1'b0, 32'h0});
        issue(1'b1, SH, 32'h0000_0102, 32'hAAAA_BEEF);
        stable = 0;
        for (int i = 0; i < 4; i++) begin
            if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} === {2'b11, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0100})
                stable++;
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        n_checks++;
        if (stable !== 4) $display("FAIL sh_stable: got %0d stable bus cycles, required 4", stable);
        else n_pass++;
        n_checks++;
        if ({resp_valid, mem_req, mem_we} !== 3'b100)
            $display("FAIL sh_resp: got valid=%0b req=%0b we=%0b, required 1 0 0", resp_valid, mem_req, mem_we);
        else n_pass++;
        tick();
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL sh_one_shot: got valid=%0b, required 0", resp_valid);
        else n_pass++;
        sb_q.push_back('{1'b0, 32'h0});
        issue(1'b1, SBU, 32'h0000_0101, 32'h1234_56A5);
        n_checks++;
        if ({mem_be, mem_wdata} !== {4'b0010, 32'hA5A5_A5A5})
            $display("FAIL sbu_store: got be=%b wdata=%h, required 0010 a5a5a5a5", mem_be, mem_wdata);
        else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        sel_type     ms[3] = '{SW, SH, SHU};
        logic [31:0] ma[3] = '{32'h0000_0101, 32'h0000_0103, 32'h0000_0001};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{1'b1, 32'h0});
            issue(1'b0, ms[i], ma[i], 32'h0);
            n_checks++;
            if ({resp_valid, resp_err, mem_req} !== 3'b110)
                $display("FAIL misaligned_%0d: got valid=%0b err=%0b req=%0b, required 1 1 0",
                         i, resp_valid, resp_err, mem_req);
            else n_pass++;
            tick();
            n_checks++;
            if ({mem_req, req_ready} !== 2'b01)
                $display("FAIL misaligned_after_%0d: got req=%0b ready=%0b, required 0 1", i, mem_req, req_ready);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int hi;
        sb_q.push_back('{1'b1, 32'h0});
        issue(1'b0, SW, 32'h0000_0200, 32'h0);
        hi = 0;
        while (mem_req && hi < 40) begin
            hi++;
            tick();
        end
        n_checks++;
        if (hi !== 16) $display("FAIL timeout_len: got %0d mem_req cycles, required 16", hi);
        else n_pass++;
        n_checks++;
        if ({resp_valid, resp_err} !== 2'b11)
            $display("FAIL timeout_resp: got valid=%0b err=%0b, required 1 1", resp_valid, resp_err);
        else n_pass++;
        tick();
        // Ack in the last allowed BUS cycle wins over the timeout.
        sb_q.push_back('{1'b0, 32'hCAFE_F00D});
        issue(1'b0, SW, 32'h0000_0400, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL tie_bus: got mem_req=%0b in cycle 16, required 1", mem_req);
        else n_pass++;
        mem_rdata = 32'hCAFE_F00D;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({resp_valid, resp_err} !== 2'b10)
            $display("FAIL tie_resp: got valid=%0b err=%0b, required 1 0", resp_valid, resp_err);
        else n_pass++;
        tick();
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({resp_valid, req_ready, mem_req} !== 3'b010)
            $display("FAIL ack_idle: got valid=%0b ready=%0b req=%0b, required 0 1 0",
                     resp_valid, req_ready, mem_req);
        else n_pass++;
    endtask

    task automatic test_reset_mid_bus();
        issue(1'b0, SW, 32'h0000_0300, 32'h0);
        tick();
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL rst_bus_pre: got mem_req=%0b, required 1", mem_req);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, req_ready, mem_addr} !== {2'b01, 32'h0})
            $display("FAIL rst_bus_async: got req=%0b ready=%0b addr=%h, required 0 1 0",
                     mem_req, req_ready, mem_addr);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL rst_bus_no_resp: got valid=%0b, required 0", resp_valid);
        else n_pass++;
        do_load(SH, 32'h0000_0302, 32'h8001_7fff);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_sel   = SB;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_load_sb();
        test_extend();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_idle();
        test_reset_mid_bus();
        tick();
        tick();
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL sb_drain: got %0d pending responses, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
